// File: rtl/micro_div_pkg.sv
// Shared types and constants for the micro restoring divider.
package micro_div_pkg;
  localparam int DIV_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] UIO_OE   = 8'b0000_1110;
  localparam int         UIO_START = 0;
  localparam int         UIO_BUSY  = 1;
  localparam int         UIO_DONE  = 2;
  localparam int         UIO_DBZ   = 3;
endpackage

// File: rtl/micro_div_datapath.sv
// Operand, partial remainder and quotient registers plus the N+1-bit
// restoring subtract/compare step; result register is updated only on commit.
module micro_div_datapath #(
  parameter int W  = 4,
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            commit,
  input  logic            commit_dbz,
  input  logic [W-1:0]    a_in,
  input  logic [W-1:0]    b_in,
  input  logic [CW-1:0]   cnt,
  output logic [2*W-1:0]  result
);
  logic [W-1:0] a_q, b_q, q_q, q_nx;
  logic [W:0]   rem_q, rem_sh, rem_nx;

  always_comb begin
    rem_sh = {rem_q[W-1:0], a_q[cnt]};
    q_nx   = q_q;
    rem_nx = rem_sh;
    if (rem_sh >= {1'b0, b_q}) begin
      rem_nx    = rem_sh - {1'b0, b_q};
      q_nx[cnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      rem_q  <= '0;
      result <= '0;
    end else begin
      if (load) begin
        a_q   <= a_in;
        b_q   <= b_in;
        q_q   <= '0;
        rem_q <= '0;
      end else if (step) begin
        q_q   <= q_nx;
        rem_q <= rem_nx;
      end
      // Final remainder is < B (or == A when B=0), so the low W bits suffice.
      if (commit)          result <= {rem_nx[W-1:0], q_nx};
      else if (commit_dbz) result <= {a_in, {W{1'b1}}};
    end
  end
endmodule

// File: rtl/tt_um_micro_div_njp.sv
// Top: FSM + iteration counter around the restoring divider datapath.
// Optional macro MICRO_DIV_DBZ_EN short-circuits B=0 to a one-edge result.
module tt_um_micro_div_njp
  import micro_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int CW = $clog2(N);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          busy, done, dbz_q;
  logic          start, load, step, commit, dbz_hit;
  logic          unused_uio;

  assign start      = uio_in[UIO_START];
  assign unused_uio = &{1'b0, uio_in[7:1]};
  assign load       = (state == IDLE) && ena && start;
  assign step       = (state == ITER);
  assign commit     = step && (cnt == '0);

`ifdef MICRO_DIV_DBZ_EN
  assign dbz_hit = (ui_in[7:4] == '0);
`else
  assign dbz_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          cnt   <= CW'(N - 1);
          dbz_q <= dbz_hit;
          if (dbz_hit) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ITER;
            busy  <= 1'b1;
          end
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: if (!start) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  micro_div_datapath #(.W(N), .CW(CW)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .commit     (commit),
    .commit_dbz (load && dbz_hit),
    .a_in       (ui_in[3:0]),
    .b_in       (ui_in[7:4]),
    .cnt        (cnt),
    .result     (uo_out)
  );

  always_comb begin
    uio_out           = '0;
    uio_out[UIO_BUSY] = busy;
    uio_out[UIO_DONE] = done;
    uio_out[UIO_DBZ]  = dbz_q;
  end

  assign uio_oe = UIO_OE;
endmodule

// File: tb/tb_tt_um_micro_div_njp.sv
// Self-checking bench for tt_um_micro_div_njp: vector table, directed
// handshake/reset sequences, exhaustive and random operand sweeps.
module tb_tt_um_micro_div_njp;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

`ifdef MICRO_DIV_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  tt_um_micro_div_njp dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_uo(input logic [3:0] a, input logic [3:0] b);
    int q, r;
    if (b == 0) begin q = 15; r = a; end
    else begin q = a / b; r = a % b; end
    return {r[3:0], q[3:0]};
  endfunction

  function automatic int ref_lat(input logic [3:0] b);
    return (DBZ && b == 0) ? 1 : 5;
  endfunction

  // Called at a negedge; returns at a negedge after the full handshake.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input string tag);
    int lat = 0;
    logic [7:0] prev = uo_out;
    bit held = 1'b1;
    ui_in  = {b, a};
    uio_in = 8'h01;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) ui_in = 8'($urandom);
      if (!uio_out[2] && uo_out !== prev) held = 1'b0;
    end while (!uio_out[2] && lat < 20);
    chk({tag, " latency"}, lat, ref_lat(b));
    chk({tag, " uo_out"}, uo_out, ref_uo(a, b));
    chk({tag, " dbz"}, uio_out[3], DBZ && b == 0);
    chk({tag, " unused uio bits"}, uio_out & 8'hF1, 8'h00);
    if (lat > 1) chk({tag, " uo hold"}, held, 1'b1);
    @(negedge clk);
    uio_in = 8'h00;
    @(posedge clk); #1;
    chk({tag, " done release"}, uio_out[2:1], 2'b00);
    chk({tag, " uo after release"}, uo_out, ref_uo(a, b));
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] uo;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int busy_rises;
    logic last_busy;
    vecs[0] = '{4'd13, 4'd3, 8'h14};
    vecs[1] = '{4'd15, 4'd1, 8'h0F};
    vecs[2] = '{4'd2,  4'd7, 8'h20};
    vecs[3] = '{4'd0,  4'd5, 8'h00};
    vecs[4] = '{4'd9,  4'd0, 8'h9F};

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h0E);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First op starts on the very first edge after release.
    foreach (vecs[i]) begin
      chk($sformatf("table model %0d", i), ref_uo(vecs[i].a, vecs[i].b), vecs[i].uo);
      do_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
    end

    // Start pulse, ena dropped mid-op: busy for 4 edges, done on 5th.
    ui_in = {4'd3, 4'd13}; uio_in = 8'h01;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin uio_in = 8'h00; ena = 1'b0; ui_in = 8'hFF; end
      chk($sformatf("pulse busy e%0d", e), uio_out[1], e < 5);
      chk($sformatf("pulse done e%0d", e), uio_out[2], e == 5);
    end
    chk("pulse result", uo_out, 8'h14);
    @(posedge clk); #1;
    chk("pulse back idle", uio_out[2:1], 2'b00);

    // Start ignored while ena=0.
    @(negedge clk); uio_in = 8'h01; ui_in = 8'h12;
    repeat (3) @(posedge clk); #1;
    chk("ena=0 ignores start", uio_out[2:1], 2'b00);
    @(negedge clk); uio_in = 8'h00; ena = 1'b1;

    // Reset mid-ITER abandons the operation.
    ui_in = {4'd3, 4'd13}; uio_in = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("async rst uo_out", uo_out, 8'h00);
    chk("async rst busy", uio_out[1], 1'b0);
    uio_in = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("post-rst idle flags", uio_out, 8'h00);
    chk("post-rst uo_out", uo_out, 8'h00);

    // Start held 10 edges: exactly one operation.
    @(negedge clk); ui_in = {4'd2, 4'd11}; uio_in = 8'h01;
    busy_rises = 0; last_busy = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (uio_out[1] && !last_busy) busy_rises++;
      last_busy = uio_out[1];
    end
    chk("held start done", uio_out[2], 1'b1);
    @(negedge clk); uio_in = 8'h00;
    repeat (4) begin
      @(posedge clk); #1;
      if (uio_out[1] && !last_busy) busy_rises++;
      last_busy = uio_out[1];
    end
    chk("held start one op", busy_rises, 1);
    chk("held start result", uo_out, 8'h15);
    @(negedge clk);

    for (int p = 0; p < 256; p++) do_op(4'(p), 4'(p >> 4), "exh");
    repeat (40) do_op(4'($urandom), 4'($urandom), "rnd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
